// File: rtl/chx_pkt_ingress_buf.sv
// chx_pkt_ingress_buf: per-channel ingress packet buffer.
// Accepts one sop/eop-framed beat stream and stores whole packets in separate
// high/low QoS buffer regions. Only fully committed packets are offered to the
// downstream round-robin arbiter. Each packet is offered through a one-hot
// rr_req and released on the matching rr_ack. High class is always read
// before low. Framing errors, overflow and over-length packets are dropped.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   chx_vld_in/data_in/sop_in/eop_in   input beat stream
//   chx_qos_in, chx_id_in              class / destination, sampled on sop
//   pkg_cnt_incr, pkg_drop             1-cycle pulses per committed / dropped packet
//   rr_req, rr_ack                     one-hot request to arbiter and its grant
//   chx_vld_out/data_out/sop_out/eop_out/qos_out   output beat stream
//   drop_cnt                           saturating drop counter (CHX_DROP_CNT_EN only)
//
// Optional feature macro: CHX_DROP_CNT_EN adds the 16-bit drop_cnt port.
module chx_pkt_ingress_buf #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DESC_DEPTH = 16,
  parameter int unsigned MAX_PKT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chx_vld_in,
  input  logic [DATA_W-1:0]      chx_data_in,
  input  logic                   chx_sop_in,
  input  logic                   chx_eop_in,
  input  logic                   chx_qos_in,
  input  logic [ID_W-1:0]        chx_id_in,
  output logic                   pkg_cnt_incr,
  output logic                   pkg_drop,
  output logic [(2**ID_W)-1:0]   rr_req,
  input  logic [(2**ID_W)-1:0]   rr_ack,
  output logic                   chx_vld_out,
  output logic [DATA_W-1:0]      chx_data_out,
  output logic                   chx_sop_out,
  output logic                   chx_eop_out,
  output logic                   chx_qos_out
`ifdef CHX_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned NUM_CH = 2**ID_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned DP_W   = $clog2(DESC_DEPTH);
  localparam int unsigned DPTR_W = DP_W + 1;
  localparam int unsigned LEN_W  = $clog2(MAX_PKT + 1);
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } desc_t;

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_SEND} rd_state_e;

  // Storage: index 1 = high class, 0 = low class. Words are {eop, data}.
  logic [WORD_W-1:0] buf_mem  [2][DEPTH];
  desc_t             desc_mem [2][DESC_DEPTH];

  // Write side state
  logic [1:0][PTR_W-1:0]  wspec_q, wspec_d;
  logic [1:0][PTR_W-1:0]  wcom_q, wcom_d;
  logic [1:0][DPTR_W-1:0] dwp_q, dwp_d;
  logic                   open_q, open_d;
  logic                   disc_q, disc_d;
  logic                   cqos_q, cqos_d;
  logic [ID_W-1:0]        cid_q, cid_d;
  logic [LEN_W-1:0]       clen_q, clen_d;
  logic                   pkg_cnt_incr_q, pkg_drop_q;

  // Read side state
  rd_state_e              state_q, state_d;
  logic [1:0][PTR_W-1:0]  rptr_q, rptr_d;
  logic [1:0][DPTR_W-1:0] drp_q, drp_d;
  logic                   rcls_q, rcls_d;
  logic [LEN_W-1:0]       rcnt_q, rcnt_d;
  logic [NUM_CH-1:0]      rr_req_q, rr_req_d;
  logic                   vld_out_q, vld_out_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   sop_out_q, sop_out_d;
  logic                   eop_out_q, eop_out_d;
  logic                   qos_out_q, qos_out_d;

  // Write-side combinational controls
  logic              mem_we_c;
  logic              wcls_c;
  logic [ID_W-1:0]   wid_c;
  logic [PTR_W-1:0]  wptr_c;
  logic [LEN_W-1:0]  wlen_c;
  logic              accept_c;
  logic              commit_c;
  logic              drop_c;
  logic              desc_we_c;
  desc_t             desc_wdata_c;
  logic [1:0]        desc_full_c;
  logic [1:0]        desc_empty_c;

  // Read-side combinational signals
  logic              sel_cls_c;
  desc_t             head_sel_c;
  desc_t             head_c;
  logic [PTR_W-1:0]  raddr_c;
  logic [WORD_W-1:0] rd_word_c;

  function automatic logic buf_full(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp);
    return (wp - rp) == PTR_W'(DEPTH);
  endfunction

  // Descriptor FIFO occupancy per class
  assign desc_full_c[0]  = (dwp_q[0] - drp_q[0]) == DPTR_W'(DESC_DEPTH);
  assign desc_full_c[1]  = (dwp_q[1] - drp_q[1]) == DPTR_W'(DESC_DEPTH);
  assign desc_empty_c[0] = dwp_q[0] == drp_q[0];
  assign desc_empty_c[1] = dwp_q[1] == drp_q[1];

  // Write path: framing, drop decisions, commit
  always_comb begin
    wspec_d      = wspec_q;
    wcom_d       = wcom_q;
    dwp_d        = dwp_q;
    open_d       = open_q;
    disc_d       = disc_q;
    cqos_d       = cqos_q;
    cid_d        = cid_q;
    clen_d       = clen_q;
    wcls_c       = cqos_q;
    wid_c        = cid_q;
    wptr_c       = wspec_q[cqos_q];
    wlen_c       = clen_q;
    accept_c     = 1'b0;
    mem_we_c     = 1'b0;
    commit_c     = 1'b0;
    drop_c       = 1'b0;
    desc_we_c    = 1'b0;
    desc_wdata_c = '0;

    if (chx_vld_in) begin
      if (chx_sop_in) begin
        // A sop inside a live packet kills the old one; the new one starts now.
        if (open_q && !disc_q) begin
          drop_c           = 1'b1;
          wspec_d[cqos_q]  = wcom_q[cqos_q];
        end
        // No packet is live in the new class after the rewind, so spec == committed.
        wcls_c = chx_qos_in;
        wid_c  = chx_id_in;
        wptr_c = wcom_q[chx_qos_in];
        wlen_c = '0;
        cqos_d = chx_qos_in;
        cid_d  = chx_id_in;
        clen_d = '0;
        open_d = 1'b1;
        disc_d = 1'b0;
        if (desc_full_c[chx_qos_in] || buf_full(wptr_c, rptr_q[chx_qos_in])) begin
          drop_c = 1'b1;
          disc_d = 1'b1;
        end else begin
          accept_c = 1'b1;
        end
        if (chx_eop_in) begin
          open_d = 1'b0;
          disc_d = 1'b0;
        end
      end else if (open_q) begin
        if (!disc_q) begin
          if (buf_full(wptr_c, rptr_q[cqos_q]) || clen_q == LEN_W'(MAX_PKT)) begin
            drop_c          = 1'b1;
            wspec_d[cqos_q] = wcom_q[cqos_q];
            disc_d          = 1'b1;
          end else begin
            accept_c = 1'b1;
          end
        end
        if (chx_eop_in) begin
          open_d = 1'b0;
          disc_d = 1'b0;
        end
      end
    end

    if (accept_c) begin
      mem_we_c        = 1'b1;
      wspec_d[wcls_c] = wptr_c + PTR_W'(1);
      clen_d          = wlen_c + LEN_W'(1);
      if (chx_eop_in) begin
        commit_c          = 1'b1;
        wcom_d[wcls_c]    = wptr_c + PTR_W'(1);
        desc_we_c         = 1'b1;
        desc_wdata_c.id   = wid_c;
        desc_wdata_c.len  = wlen_c + LEN_W'(1);
        dwp_d[wcls_c]     = dwp_q[wcls_c] + DPTR_W'(1);
      end
    end
  end

  // Packet and descriptor storage (no reset: emptiness is tracked by pointers)
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      buf_mem[wcls_c][wptr_c[ADDR_W-1:0]] <= {chx_eop_in, chx_data_in};
    end
    if (desc_we_c) begin
      desc_mem[wcls_c][dwp_q[wcls_c][DP_W-1:0]] <= desc_wdata_c;
    end
  end

  // Read-side lookups: class choice in IDLE, head descriptor and RAM word in SEND
  assign sel_cls_c  = !desc_empty_c[1];
  assign head_sel_c = desc_mem[sel_cls_c][drp_q[sel_cls_c][DP_W-1:0]];
  assign head_c     = desc_mem[rcls_q][drp_q[rcls_q][DP_W-1:0]];
  assign raddr_c    = rptr_q[rcls_q] + PTR_W'(rcnt_q);
  assign rd_word_c  = buf_mem[rcls_q][raddr_c[ADDR_W-1:0]];

  // Read FSM: next state and registered outputs
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    drp_d      = drp_q;
    rcls_d     = rcls_q;
    rcnt_d     = rcnt_q;
    rr_req_d   = rr_req_q;
    vld_out_d  = 1'b0;
    sop_out_d  = 1'b0;
    eop_out_d  = 1'b0;
    data_out_d = data_out_q;
    qos_out_d  = qos_out_q;

    case (state_q)
      RD_IDLE: begin
        if (!desc_empty_c[0] || !desc_empty_c[1]) begin
          state_d  = RD_REQ;
          rcls_d   = sel_cls_c;
          rcnt_d   = '0;
          rr_req_d = NUM_CH'(1) << head_sel_c.id;
        end
      end
      RD_REQ: begin
        if (|(rr_ack & rr_req_q)) begin
          state_d  = RD_SEND;
          rr_req_d = '0;
        end
      end
      RD_SEND: begin
        vld_out_d  = 1'b1;
        sop_out_d  = rcnt_q == '0;
        eop_out_d  = rd_word_c[DATA_W];
        data_out_d = rd_word_c[DATA_W-1:0];
        qos_out_d  = rcls_q;
        rcnt_d     = rcnt_q + LEN_W'(1);
        // Last read issued: release the packet's words and descriptor.
        if (rcnt_q == head_c.len - LEN_W'(1)) begin
          state_d        = RD_IDLE;
          rptr_d[rcls_q] = rptr_q[rcls_q] + PTR_W'(head_c.len);
          drp_d[rcls_q]  = drp_q[rcls_q] + DPTR_W'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wspec_q        <= '0;
      wcom_q         <= '0;
      dwp_q          <= '0;
      open_q         <= 1'b0;
      disc_q         <= 1'b0;
      cqos_q         <= 1'b0;
      cid_q          <= '0;
      clen_q         <= '0;
      pkg_cnt_incr_q <= 1'b0;
      pkg_drop_q     <= 1'b0;
      state_q        <= RD_IDLE;
      rptr_q         <= '0;
      drp_q          <= '0;
      rcls_q         <= 1'b0;
      rcnt_q         <= '0;
      rr_req_q       <= '0;
      vld_out_q      <= 1'b0;
      data_out_q     <= '0;
      sop_out_q      <= 1'b0;
      eop_out_q      <= 1'b0;
      qos_out_q      <= 1'b0;
    end else begin
      wspec_q        <= wspec_d;
      wcom_q         <= wcom_d;
      dwp_q          <= dwp_d;
      open_q         <= open_d;
      disc_q         <= disc_d;
      cqos_q         <= cqos_d;
      cid_q          <= cid_d;
      clen_q         <= clen_d;
      pkg_cnt_incr_q <= commit_c;
      pkg_drop_q     <= drop_c;
      state_q        <= state_d;
      rptr_q         <= rptr_d;
      drp_q          <= drp_d;
      rcls_q         <= rcls_d;
      rcnt_q         <= rcnt_d;
      rr_req_q       <= rr_req_d;
      vld_out_q      <= vld_out_d;
      data_out_q     <= data_out_d;
      sop_out_q      <= sop_out_d;
      eop_out_q      <= eop_out_d;
      qos_out_q      <= qos_out_d;
    end
  end

`ifdef CHX_DROP_CNT_EN
  // Saturating count of dropped packets
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign pkg_cnt_incr = pkg_cnt_incr_q;
  assign pkg_drop     = pkg_drop_q;
  assign rr_req       = rr_req_q;
  assign chx_vld_out  = vld_out_q;
  assign chx_data_out = data_out_q;
  assign chx_sop_out  = sop_out_q;
  assign chx_eop_out  = eop_out_q;
  assign chx_qos_out  = qos_out_q;

endmodule

// File: tb/tb_chx_pkt_ingress_buf.sv
// Directed bench for chx_pkt_ingress_buf, built with a 16-word buffer so that
// overflow, descriptor-full and pointer wrap are reachable in short runs.
module tb_chx_pkt_ingress_buf;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned DESC_DEPTH = 16;
  localparam int unsigned MAX_PKT    = 16;

  logic              clk;
  logic              rst_n;
  logic              chx_vld_in;
  logic [DATA_W-1:0] chx_data_in;
  logic              chx_sop_in;
  logic              chx_eop_in;
  logic              chx_qos_in;
  logic [ID_W-1:0]   chx_id_in;
  logic              pkg_cnt_incr;
  logic              pkg_drop;
  logic [NUM_CH-1:0] rr_req;
  logic [NUM_CH-1:0] rr_ack;
  logic              chx_vld_out;
  logic [DATA_W-1:0] chx_data_out;
  logic              chx_sop_out;
  logic              chx_eop_out;
  logic              chx_qos_out;
`ifdef CHX_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  chx_pkt_ingress_buf #(
    .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
    .DESC_DEPTH(DESC_DEPTH), .MAX_PKT(MAX_PKT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .chx_vld_in(chx_vld_in), .chx_data_in(chx_data_in),
    .chx_sop_in(chx_sop_in), .chx_eop_in(chx_eop_in),
    .chx_qos_in(chx_qos_in), .chx_id_in(chx_id_in),
    .pkg_cnt_incr(pkg_cnt_incr), .pkg_drop(pkg_drop),
    .rr_req(rr_req), .rr_ack(rr_ack),
    .chx_vld_out(chx_vld_out), .chx_data_out(chx_data_out),
    .chx_sop_out(chx_sop_out), .chx_eop_out(chx_eop_out),
    .chx_qos_out(chx_qos_out)
`ifdef CHX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output beats as {qos, sop, eop, data}
  logic [10:0] out_q [$];
  int n_commit = 0;
  int n_drop   = 0;
  int n_pass   = 0;
  int n_total  = 0;

  // Monitor: records output beats and counts pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (chx_vld_out) out_q.push_back({chx_qos_out, chx_sop_out, chx_eop_out, chx_data_out});
      if (pkg_cnt_incr) n_commit++;
      if (pkg_drop) n_drop++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic s, input logic e, input logic q,
                      input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    @(negedge clk);
    chx_vld_in  = 1'b1;
    chx_sop_in  = s;
    chx_eop_in  = e;
    chx_qos_in  = q;
    chx_id_in   = id;
    chx_data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chx_vld_in = 1'b0;
      chx_sop_in = 1'b0;
      chx_eop_in = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic q, input logic [ID_W-1:0] id, input int n,
                          input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      beat(i == 0, i == n - 1, q, id, base + DATA_W'(i));
    end
    idle(1);
  endtask

  task automatic wait_req(output logic [NUM_CH-1:0] r);
    r = rr_req;
    for (int i = 0; i < 80 && r == '0; i++) begin
      @(negedge clk);
      r = rr_req;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    rr_ack = rr_req;
    @(negedge clk);
    rr_ack = '0;
  endtask

  task automatic expect_pkt(input string tag, input logic q, input int n,
                            input logic [DATA_W-1:0] base);
    logic [10:0] got;
    logic [10:0] exp;
    for (int i = 0; i < 80 && out_q.size() < n; i++) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      got = '0;
      if (out_q.size() > 0) got = out_q.pop_front();
      exp = {q, i == 0, i == n - 1, base + DATA_W'(i)};
      check($sformatf("%s_beat%0d", tag, i), 32'(got), 32'(exp));
    end
  endtask

  logic [NUM_CH-1:0] r;
  int c0;
  int d0;

  initial begin
    rst_n       = 1'b0;
    chx_vld_in  = 1'b0;
    chx_data_in = '0;
    chx_sop_in  = 1'b0;
    chx_eop_in  = 1'b0;
    chx_qos_in  = 1'b0;
    chx_id_in   = '0;
    rr_ack      = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rr_req", 32'(rr_req), 32'h0);
    check("rst_outs", 32'({chx_vld_out, chx_sop_out, chx_eop_out, chx_qos_out,
                           pkg_cnt_incr, pkg_drop}), 32'h0);
    check("rst_data", 32'(chx_data_out), 32'h0);
`ifdef CHX_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    idle(2);

    // 4-beat low packet to id 5; stray ack bits must be ignored
    c0 = n_commit; d0 = n_drop;
    send_pkt(1'b0, 3'd5, 4, 8'h11);
    wait_req(r);
    check("t1_req", 32'(r), 32'h20);
    check("t1_commit", 32'(n_commit - c0), 32'd1);
    @(negedge clk); rr_ack = 8'hDF;
    @(negedge clk); rr_ack = '0;
    idle(2);
    check("t1_req_held", 32'(rr_req), 32'h20);
    check("t1_no_out", 32'(out_q.size()), 32'd0);
    do_ack();
    expect_pkt("t1", 1'b0, 4, 8'h11);
    check("t1_drops", 32'(n_drop - d0), 32'd0);

    // High packet overtakes an earlier low packet while the reader is busy
    send_pkt(1'b0, 3'd0, 2, 8'hA0);
    wait_req(r);
    check("t2_req_a", 32'(r), 32'h01);
    send_pkt(1'b0, 3'd1, 3, 8'h21);
    send_pkt(1'b1, 3'd6, 2, 8'h31);
    idle(2);
    do_ack();
    expect_pkt("t2a", 1'b0, 2, 8'hA0);
    wait_req(r);
    check("t2_req_hi", 32'(r), 32'h40);
    do_ack();
    expect_pkt("t2hi", 1'b1, 2, 8'h31);
    wait_req(r);
    check("t2_req_lo", 32'(r), 32'h02);
    do_ack();
    expect_pkt("t2lo", 1'b0, 3, 8'h21);

    // 20-beat packet overflows the 16-word buffer on beat 17
    c0 = n_commit; d0 = n_drop;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 16) check("t3_no_drop_at16", 32'(pkg_drop), 32'd0);
      if (i == 17) check("t3_drop_at17", 32'(pkg_drop), 32'd1);
      chx_vld_in  = 1'b1;
      chx_sop_in  = (i == 0);
      chx_eop_in  = (i == 19);
      chx_qos_in  = 1'b0;
      chx_id_in   = 3'd3;
      chx_data_in = 8'h40 + 8'(i);
    end
    idle(4);
    check("t3_no_req", 32'(rr_req), 32'h0);
    check("t3_commit", 32'(n_commit - c0), 32'd0);
    check("t3_drops", 32'(n_drop - d0), 32'd1);
    send_pkt(1'b0, 3'd4, 3, 8'h70);
    wait_req(r);
    check("t3_req_next", 32'(r), 32'h10);
    do_ack();
    expect_pkt("t3next", 1'b0, 3, 8'h70);

    // sop inside an open packet: old one dropped, new 1-beat packet to id 2 kept
    c0 = n_commit; d0 = n_drop;
    beat(1'b1, 1'b0, 1'b0, 3'd7, 8'h50);
    beat(1'b0, 1'b0, 1'b0, 3'd7, 8'h51);
    beat(1'b0, 1'b0, 1'b0, 3'd7, 8'h52);
    beat(1'b1, 1'b1, 1'b0, 3'd2, 8'h5A);
    idle(1);
    wait_req(r);
    check("t4_req", 32'(r), 32'h04);
    check("t4_drops", 32'(n_drop - d0), 32'd1);
    check("t4_commit", 32'(n_commit - c0), 32'd1);
    do_ack();
    expect_pkt("t4", 1'b0, 1, 8'h5A);

    // Fresh reset, then 17 one-beat packets with no ack: descriptor FIFO full
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    c0 = n_commit; d0 = n_drop;
    for (int i = 0; i < 17; i++) send_pkt(1'b0, 3'(i % 8), 1, 8'h60 + 8'(i));
    idle(2);
    check("t5_commit", 32'(n_commit - c0), 32'd16);
    check("t5_drops", 32'(n_drop - d0), 32'd1);
`ifdef CHX_DROP_CNT_EN
    check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      wait_req(r);
      check($sformatf("t5_req%0d", i), 32'(r), 32'(8'(1) << (i % 8)));
      do_ack();
      expect_pkt($sformatf("t5p%0d", i), 1'b0, 1, 8'h60 + 8'(i));
    end

    // Pointer wrap: 3*DEPTH beats in 8-beat packets with prompt acks
    c0 = n_commit; d0 = n_drop;
    for (int k = 0; k < 6; k++) begin
      send_pkt(1'b0, 3'(k), 8, 8'h80 + 8'(8 * k));
      wait_req(r);
      check($sformatf("t6_req%0d", k), 32'(r), 32'(8'(1) << k));
      do_ack();
      expect_pkt($sformatf("t6p%0d", k), 1'b0, 8, 8'h80 + 8'(8 * k));
    end
    check("t6_commit", 32'(n_commit - c0), 32'd6);
    check("t6_drops", 32'(n_drop - d0), 32'd0);
    idle(4);
    check("end_out_empty", 32'(out_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
